// File: rtl/mem_arbiter_rr.sv
// Arbitrates NUM_PORTS line requesters onto one downstream line port.
// Round-robin or fixed-priority selection, registered grant, one release cycle per transaction.
module mem_arbiter_rr #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int LINE_WIDTH    = 128,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic [LINE_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_resp,
    output logic [1:0]                       dbg_state_o
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [GW-1:0] LAST_RST = GW'(NUM_PORTS - 1);

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic                  op_read_q, op_read_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_PORTS-1:0]  pending;
    logic [GW-1:0]         winner;
    logic                  busy;

    assign pending = req_read | req_write;

    // Search order starts just after the last winner (round-robin) or at port 0 (fixed).
    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (PRIORITY_MODE == 1) begin
                idx = k;
            end else begin
                idx = (int'(last_grant_q) + 1 + k) % NUM_PORTS;
            end
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_read_d    = op_read_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    state_d      = ST_BUSY;
                    grant_d      = winner;
                    last_grant_d = winner;
                    // A simultaneous read and write collapses to a write.
                    op_write_d   = req_write[winner];
                    op_read_d    = req_read[winner] & ~req_write[winner];
                    addr_d       = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = req_wdata[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
                end
            end
            ST_BUSY: begin
                if (mem_resp) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            op_read_q    <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_read_q    <= op_read_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Downstream outputs are driven only while a transaction is outstanding.
    assign busy        = (state_q == ST_BUSY);
    assign mem_read    = busy & op_read_q;
    assign mem_write   = busy & op_write_q;
    assign mem_addr    = busy ? addr_q  : '0;
    assign mem_wdata   = busy ? wdata_q : '0;
    assign req_rdata   = mem_rdata;
    assign req_resp    = (busy && mem_resp) ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign dbg_state_o = state_q;

endmodule
